// File: rtl/spi_master_ctrl.sv
// SPI mode-0 transfer controller: shifts one byte out MSB-first on MOSI while
// capturing MISO, framing the transfer with CS_N and ending with a DONE strobe.
module spi_master_ctrl #(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 8
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              START,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic              CS_N,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] RX_DATA
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SCLK_HI,
      SCLK_LO
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_sr;
   logic [DATA_W-1:0] rx_sr;
   logic              div_end;
   logic              last_bit;

   assign div_end  = (div_cnt == DIV_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) state <= IDLE;
      else     state <= state_nxt;
   end

   // Pin levels are decoded from the state so CLR forces them idle without a clock.
   always_comb begin
      state_nxt = state;
      SCLK      = 1'b0;
      CS_N      = 1'b1;
      BUSY      = 1'b0;
      MOSI      = 1'b0;
      case (state)
         IDLE: begin
            if (START) state_nxt = SETUP;
         end
         SETUP: begin
            CS_N = 1'b0;
            BUSY = 1'b1;
            MOSI = tx_sr[DATA_W-1];
            if (div_end) state_nxt = SCLK_HI;
         end
         SCLK_HI: begin
            SCLK = 1'b1;
            CS_N = 1'b0;
            BUSY = 1'b1;
            MOSI = tx_sr[DATA_W-1];
            if (div_end) state_nxt = SCLK_LO;
         end
         SCLK_LO: begin
            CS_N = 1'b0;
            BUSY = 1'b1;
            MOSI = tx_sr[DATA_W-1];
            if (div_end) state_nxt = last_bit ? IDLE : SCLK_HI;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         DONE    <= 1'b0;
         RX_DATA <= '0;
      end else begin
         DONE <= 1'b0;
         if (state == IDLE || div_end) div_cnt <= '0;
         else                          div_cnt <= div_cnt + 1'b1;

         if (state == IDLE && START) begin
            tx_sr   <= TX_DATA;
            bit_cnt <= '0;
         end

         // MISO is sampled on the edge that raises SCLK; bit_cnt saturates at DATA_W.
         if (state != SCLK_HI && state_nxt == SCLK_HI) begin
            rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
         end

         // After the final rise the last bit is held on MOSI instead of shifting.
         if (state == SCLK_HI && div_end && !last_bit)
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};

         if (state == SCLK_LO && div_end && last_bit) begin
            DONE    <= 1'b1;
            RX_DATA <= rx_sr;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=2 and 1) checked every
// cycle against a time-indexed transfer model, plus directed literal checks.
module tb_spi_master_ctrl;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   int   div [2] = '{2, 1};
   logic start [2];
   logic [7:0] tx [2];
   logic loop [2];
   logic rnd_miso [2];
   logic miso_w [2];
   logic sclk_o [2], mosi_o [2], cs_n_o [2], busy_o [2], done_o [2];
   logic [7:0] rx_o [2];

   assign miso_w[0] = loop[0] ? mosi_o[0] : rnd_miso[0];
   assign miso_w[1] = loop[1] ? mosi_o[1] : rnd_miso[1];

   spi_master_ctrl #(.CLK_DIV(2), .DATA_W(8)) dut0 (
      .CLK(clk), .CLR(clr), .START(start[0]), .TX_DATA(tx[0]), .MISO(miso_w[0]),
      .SCLK(sclk_o[0]), .MOSI(mosi_o[0]), .CS_N(cs_n_o[0]), .BUSY(busy_o[0]),
      .DONE(done_o[0]), .RX_DATA(rx_o[0]));

   spi_master_ctrl #(.CLK_DIV(1), .DATA_W(8)) dut1 (
      .CLK(clk), .CLR(clr), .START(start[1]), .TX_DATA(tx[1]), .MISO(miso_w[1]),
      .SCLK(sclk_o[1]), .MOSI(mosi_o[1]), .CS_N(cs_n_o[1]), .BUSY(busy_o[1]),
      .DONE(done_o[1]), .RX_DATA(rx_o[1]));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Model: t counts cycles since the accepting edge (0 = idle). Cycle t of a
   // transfer lies in phase p=(t-1)/div: p=0 setup, odd p SCLK high, even p low.
   function automatic logic f_mosi(int t, logic [7:0] b, int d);
      int p, k;
      if (t == 0) return 1'b0;
      p = (t - 1) / d;
      if (p == 0) return b[7];
      k = (p - 1) / 2;
      if ((p - 1) % 2 == 0) return b[7-k];
      return (k < 7) ? b[6-k] : b[0];
   endfunction

   function automatic logic f_sclk(int t, int d);
      int p;
      if (t == 0) return 1'b0;
      p = (t - 1) / d;
      return (p >= 1) && ((p - 1) % 2 == 0);
   endfunction

   int t [2] = '{0, 0};
   logic [7:0] cur_tx [2] = '{8'h00, 8'h00};
   logic [7:0] rx_acc [2] = '{8'h00, 8'h00};
   logic [7:0] exp_rx [2] = '{8'h00, 8'h00};
   logic exp_done [2] = '{1'b0, 1'b0};
   int cyc = 0;
   int acc_cyc [2] = '{0, 0};

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < 2; i++) begin
            t[i] = 0; rx_acc[i] = 8'h00; exp_rx[i] = 8'h00; exp_done[i] = 1'b0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            logic m;
            m = loop[i] ? f_mosi(t[i], cur_tx[i], div[i]) : rnd_miso[i];
            exp_done[i] = 1'b0;
            if (t[i] == 17 * div[i]) begin
               t[i] = 0;
               exp_done[i] = 1'b1;
               exp_rx[i] = rx_acc[i];
            end else if (t[i] == 0) begin
               if (start[i]) begin
                  t[i] = 1; cur_tx[i] = tx[i]; acc_cyc[i] = cyc;
               end
            end else begin
               t[i]++;
               if ((t[i] - 1) % div[i] == 0 && ((t[i] - 1) / div[i]) % 2 == 1)
                  rx_acc[i] = {rx_acc[i][6:0], m};
            end
         end
      end
   end

   int busy_cnt [2] = '{0, 0};
   int rise_cnt [2] = '{0, 0};
   int done_cnt [2] = '{0, 0};
   logic sclk_prev [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("sclk%0d", i), sclk_o[i], f_sclk(t[i], div[i]));
         chk($sformatf("cs_n%0d", i), cs_n_o[i], t[i] == 0);
         chk($sformatf("busy%0d", i), busy_o[i], t[i] != 0);
         chk($sformatf("mosi%0d", i), mosi_o[i], f_mosi(t[i], cur_tx[i], div[i]));
         chk($sformatf("done%0d", i), done_o[i], exp_done[i]);
         chk($sformatf("rx%0d", i), rx_o[i], exp_rx[i]);
         if (busy_o[i]) busy_cnt[i]++;
         if (sclk_o[i] && !sclk_prev[i]) rise_cnt[i]++;
         sclk_prev[i] = sclk_o[i];
         if (done_o[i]) begin
            done_cnt[i]++;
            chk($sformatf("done_lat%0d", i), cyc - acc_cyc[i], 17 * div[i]);
         end
      end
   end

   task automatic run_xfer(input int i, input logic [7:0] d);
      @(posedge clk); #1;
      tx[i] = d; start[i] = 1'b1;
      busy_cnt[i] = 0; rise_cnt[i] = 0; done_cnt[i] = 0;
      @(posedge clk); #1;
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
         @(negedge clk); #1;
         if (done_o[i]) got = 1'b1;
      end
      chk($sformatf("done_seen%0d", i), got, 1'b1);
   endtask

   task automatic wait_rises(input int i, input int r);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk); #1;
         if (rise_cnt[i] == r) got = 1'b1;
      end
      chk("rise_wait", got, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; tx[i] = 8'h00; loop[i] = 1'b0; rnd_miso[i] = 1'b0;
      end
      #1 clr = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            start[i] = 1'($urandom); tx[i] = 8'($urandom); rnd_miso[i] = 1'($urandom);
         end
      end
      chk("rst_sclk", sclk_o[0], 1'b0);
      chk("rst_cs_n", cs_n_o[0], 1'b1);
      chk("rst_rx", rx_o[0], 8'h00);
      for (int i = 0; i < 2; i++) start[i] = 1'b0;
      @(posedge clk); #2 clr = 1'b0;

      // Loopback 0xA5 at CLK_DIV=2.
      loop[0] = 1'b1;
      run_xfer(0, 8'hA5);
      wait_done(0);
      chk("lb_rx", rx_o[0], 8'hA5);
      chk("lb_busy", busy_cnt[0], 34);
      chk("lb_rises", rise_cnt[0], 8);
      @(negedge clk); #1;
      chk("lb_done_w", done_o[0], 1'b0);

      // Constant MISO at CLK_DIV=1.
      loop[1] = 1'b0; rnd_miso[1] = 1'b1;
      run_xfer(1, 8'h3C);
      wait_done(1);
      chk("miso1_rx", rx_o[1], 8'hFF);
      rnd_miso[1] = 1'b0;
      run_xfer(1, 8'h3C);
      wait_done(1);
      chk("miso0_rx", rx_o[1], 8'h00);

      // START and new TX_DATA mid-transfer are ignored.
      run_xfer(0, 8'h81);
      repeat (10) @(posedge clk);
      #1 start[0] = 1'b1; tx[0] = 8'hFF;
      @(posedge clk); #1 start[0] = 1'b0;
      wait_done(0);
      chk("ign_rx", rx_o[0], 8'h81);
      repeat (40) @(posedge clk);
      #1 chk("ign_done_cnt", done_cnt[0], 1);

      // Asynchronous CLR after the 4th SCLK rise.
      run_xfer(0, 8'h96);
      wait_rises(0, 4);
      @(posedge clk); #3 clr = 1'b1;
      #1;
      chk("aclr_sclk", sclk_o[0], 1'b0);
      chk("aclr_cs_n", cs_n_o[0], 1'b1);
      chk("aclr_busy", busy_o[0], 1'b0);
      chk("aclr_mosi", mosi_o[0], 1'b0);
      chk("aclr_rx", rx_o[0], 8'h00);
      #3 clr = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("aclr_no_done", done_cnt[0], 0);
      run_xfer(0, 8'h5A);
      wait_done(0);
      chk("post_clr_rx", rx_o[0], 8'h5A);

      // START held high: back-to-back 0x12 then 0x34.
      @(posedge clk); #1 tx[0] = 8'h12; start[0] = 1'b1;
      @(posedge clk); #1 tx[0] = 8'h34;
      wait_done(0);
      chk("b2b_rx1", rx_o[0], 8'h12);
      chk("b2b_cs_gap", cs_n_o[0], 1'b1);
      @(negedge clk); #1;
      chk("b2b_cs_low", cs_n_o[0], 1'b0);
      wait_done(0);
      start[0] = 1'b0;
      chk("b2b_rx2", rx_o[0], 8'h34);

      // Randomized traffic on both instances.
      repeat (1500) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            start[i] = ($urandom_range(0, 7) == 0);
            tx[i] = 8'($urandom);
            rnd_miso[i] = 1'($urandom);
            loop[i] = 1'($urandom);
         end
      end
      for (int i = 0; i < 2; i++) start[i] = 1'b0;
      repeat (60) @(posedge clk);
      @(negedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
